// File: rtl/board_io_ctrl.sv
// rtl/board_io_ctrl.sv - board IO conditioning: button/switch sync + debounce, press pulses, LED mode mux
module board_io_ctrl #(
  parameter int NumBtn         = 4,
  parameter int NumSw          = 4,
  parameter int NumLed         = 4,
  parameter int DebounceCycles = 50000,
  parameter int BlinkDiv       = 25000000
) (
  input  logic                clk_sys_i,
  input  logic                rst_sys_i,
  input  logic [NumBtn-1:0]   btn_i,
  input  logic [NumSw-1:0]    sw_i,
  input  logic [NumLed-1:0]   gp_i,
  input  logic [2*NumLed-1:0] led_mode_i,
  output logic [NumBtn-1:0]   btn_o,
  output logic [NumBtn-1:0]   btn_press_o,
  output logic [NumSw-1:0]    sw_o,
  output logic [NumLed-1:0]   led_o
);

  localparam int NumCh = NumBtn + NumSw;
  localparam int CntW  = $clog2(DebounceCycles + 1);
  localparam int PreW  = $clog2(BlinkDiv);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);
  localparam logic [PreW-1:0] PreLast = PreW'(BlinkDiv - 1);

  if (DebounceCycles < 1 || BlinkDiv < 2) begin : g_param_err
    $error("board_io_ctrl: DebounceCycles must be >= 1 and BlinkDiv must be >= 2");
  end

  logic [NumCh-1:0]  sync1_q, sync1_d;
  logic [NumCh-1:0]  sync2_q, sync2_d;
  logic [NumCh-1:0]  db_q, db_d;
  logic [NumBtn-1:0] db_prev_q, db_prev_d;
  logic [CntW-1:0]   cnt_q [NumCh];
  logic [CntW-1:0]   cnt_d [NumCh];
  logic [PreW-1:0]   presc_q, presc_d;
  logic              blink_phase_q, blink_phase_d;
  logic [NumLed-1:0] led_q, led_d;
  logic [NumLed-1:0] btn_term;

  // LEDs beyond the last button see a constant 0 in the legacy XOR mode
  for (genvar gi = 0; gi < NumLed; gi++) begin : g_btn_term
    if (gi < NumBtn) begin : g_has_btn
      assign btn_term[gi] = db_q[gi];
    end else begin : g_no_btn
      assign btn_term[gi] = 1'b0;
    end
  end

  always_comb begin
    sync1_d       = {sw_i, btn_i};
    sync2_d       = sync1_q;
    db_d          = db_q;
    db_prev_d     = db_q[NumBtn-1:0];
    presc_d       = presc_q + PreW'(1);
    blink_phase_d = blink_phase_q;
    led_d         = '0;
    for (int ch = 0; ch < NumCh; ch++) begin
      cnt_d[ch] = cnt_q[ch] + CntW'(1);
      if (sync2_q[ch] == db_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == CntLast) begin
        db_d[ch]  = sync2_q[ch];
        cnt_d[ch] = '0;
      end
    end
    if (presc_q == PreLast) begin
      presc_d       = '0;
      blink_phase_d = ~blink_phase_q;
    end
    for (int i = 0; i < NumLed; i++) begin
      case (led_mode_i[2*i +: 2])
        2'd0:    led_d[i] = gp_i[i];
        2'd1:    led_d[i] = gp_i[i] ^ btn_term[i];
        2'd2:    led_d[i] = blink_phase_q;
        default: led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      db_q          <= '0;
      db_prev_q     <= '0;
      cnt_q         <= '{default: '0};
      presc_q       <= '0;
      blink_phase_q <= 1'b0;
      led_q         <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      db_q          <= db_d;
      db_prev_q     <= db_prev_d;
      cnt_q         <= cnt_d;
      presc_q       <= presc_d;
      blink_phase_q <= blink_phase_d;
      led_q         <= led_d;
    end
  end

  assign btn_o       = db_q[NumBtn-1:0];
  assign sw_o        = db_q[NumCh-1:NumBtn];
  assign btn_press_o = db_q[NumBtn-1:0] & ~db_prev_q;
  assign led_o       = led_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// tb/tb_board_io_ctrl.sv - directed + randomized bench for board_io_ctrl against a window-based reference model
module tb_board_io_ctrl;
  localparam int NB = 4;
  localparam int NS = 4;
  localparam int NL = 4;
  localparam int DC = 4;
  localparam int BD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [NB-1:0] btn = '0;
  logic [NS-1:0] sw  = '0;
  logic [NL-1:0] gp  = '0;
  logic [7:0]    mode = '0;
  logic [NB-1:0] btn_o, btn_press_o;
  logic [NS-1:0] sw_o;
  logic [NL-1:0] led_o;

  board_io_ctrl #(
    .NumBtn(NB), .NumSw(NS), .NumLed(NL), .DebounceCycles(DC), .BlinkDiv(BD)
  ) dut (
    .clk_sys_i(clk), .rst_sys_i(rst), .btn_i(btn), .sw_i(sw), .gp_i(gp),
    .led_mode_i(mode), .btn_o(btn_o), .btn_press_o(btn_press_o), .sw_o(sw_o), .led_o(led_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: a level is accepted once the last DC synchronised samples all disagree with it
  logic [7:0]    hist[$];
  logic [7:0]    m_db = '0;
  logic [NB-1:0] m_press = '0;
  logic [NL-1:0] m_led = '0;
  int            m_edges = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sample(int k, int ch);
    int idx;
    idx = hist.size() - 1 - k;
    return (idx >= 0) ? hist[idx][ch] : 1'b0;
  endfunction

  task automatic model_edge();
    logic [7:0] old_db;
    logic       ph;
    logic       flip;
    old_db = m_db;
    if (rst) begin
      hist.delete();
      m_db = '0; m_press = '0; m_led = '0; m_edges = 0;
      return;
    end
    hist.push_back({sw, btn});
    if (hist.size() > 16) void'(hist.pop_front());
    ph = ((m_edges / BD) % 2) == 1;
    for (int i = 0; i < NL; i++) begin
      case (mode[2*i +: 2])
        2'd0:    m_led[i] = gp[i];
        2'd1:    m_led[i] = gp[i] ^ old_db[i];
        2'd2:    m_led[i] = ph;
        default: m_led[i] = 1'b0;
      endcase
    end
    for (int ch = 0; ch < 8; ch++) begin
      flip = 1'b1;
      for (int k = 2; k <= DC + 1; k++)
        if (sample(k, ch) == old_db[ch]) flip = 1'b0;
      if (flip) m_db[ch] = ~old_db[ch];
    end
    m_press = m_db[3:0] & ~old_db[3:0];
    m_edges++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("btn_o", 32'(btn_o), 32'(m_db[3:0]));
    check("sw_o", 32'(sw_o), 32'(m_db[7:4]));
    check("btn_press_o", 32'(btn_press_o), 32'(m_press));
    check("led_o", 32'(led_o), 32'(m_led));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int first;
    int cnt;
    logic [NB-1:0] pval;
    logic prev;

    // reset state
    ticks(3);
    check("reset_zero", 32'({btn_o, btn_press_o, sw_o, led_o}), 32'd0);
    rst = 1'b0;
    ticks(7);

    // clean press, then release
    btn = 4'b0001; first = -1; cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (btn_o[0] && first < 0) first = k;
      if (btn_press_o[0]) cnt++;
    end
    check("press_latency", 32'(first), 32'd6);
    check("press_count", 32'(cnt), 32'd1);
    btn = 4'b0000; first = -1; cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (!btn_o[0] && first < 0) first = k;
      if (btn_press_o != 0) cnt++;
    end
    check("release_latency", 32'(first), 32'd6);
    check("release_no_pulse", 32'(cnt), 32'd0);

    // glitch rejection on sw[2]
    cnt = 0;
    sw = 4'b0100; for (int k = 0; k < 3; k++) begin tick(); if (sw_o != 0) cnt++; end
    sw = 4'b0000; tick(); if (sw_o != 0) cnt++;
    sw = 4'b0100; for (int k = 0; k < 3; k++) begin tick(); if (sw_o != 0) cnt++; end
    sw = 4'b0000; for (int k = 0; k < 5; k++) begin tick(); if (sw_o != 0) cnt++; end
    check("glitch_rejected", 32'(cnt), 32'd0);
    sw = 4'b0100; first = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (sw_o[2] && first < 0) first = k;
    end
    check("sw_latency", 32'(first), 32'd6);

    // LED modes 0/1/2/3
    btn = 4'b0011; gp = 4'b1010; mode = 8'b11_10_01_00;
    ticks(8);
    check("led0_mode0", 32'(led_o[0]), 32'd0);
    check("led1_mode1", 32'(led_o[1]), 32'd0);
    check("led3_mode3", 32'(led_o[3]), 32'd0);
    cnt = 0; prev = led_o[2];
    for (int k = 0; k < 16; k++) begin
      tick();
      if (led_o[2] != prev) cnt++;
      prev = led_o[2];
    end
    check("blink_toggles", 32'(cnt), 32'd4);

    // legacy mode, random gp and buttons
    mode = 8'h55;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(3) == 0) gp = 4'($urandom);
      if ($urandom_range(5) == 0) btn = 4'($urandom);
      tick();
    end

    // reset mid-debounce with btn[3] held high
    btn = 4'b0000; ticks(8);
    btn = 4'b1000; ticks(4);
    rst = 1'b1;
    ticks(2);
    check("reset_mid_zero", 32'({btn_o, btn_press_o, sw_o, led_o}), 32'd0);
    rst = 1'b0; first = -1; cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (btn_o[3] && first < 0) first = k;
      if (btn_press_o[3]) cnt++;
    end
    check("post_reset_latency", 32'(first), 32'd6);
    check("post_reset_press", 32'(cnt), 32'd1);

    // simultaneous presses on btn 0 and 3
    btn = 4'b0000; ticks(8);
    btn = 4'b1001; cnt = 0; pval = '0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (btn_press_o != 0) begin cnt++; pval = btn_press_o; end
    end
    check("simul_press_value", 32'(pval), 32'b1001);
    check("simul_press_cycles", 32'(cnt), 32'd1);

    // random everything, including occasional resets
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(3) == 0) gp = 4'($urandom);
      if ($urandom_range(6) == 0) btn = 4'($urandom);
      if ($urandom_range(6) == 0) sw = 4'($urandom);
      if ($urandom_range(20) == 0) mode = 8'($urandom);
      rst = ($urandom_range(99) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
